// File: rtl/branch_resolve.sv
// ============================================================================
//  branch_resolve : registered branch/jump resolution with delay-slot tracking
//  Rev 1.0
// ============================================================================
`default_nettype none

module branch_resolve #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             in_valid,
  input  logic [3:0]       in_op,
  input  logic [WIDTH-1:0] in_pc,
  input  logic [15:0]      in_imm,
  input  logic [25:0]      in_index,
  input  logic [WIDTH-1:0] in_rs,
  input  logic             lt,
  input  logic             eq,
  input  logic             neq,
  input  logic             gt,
  input  logic             lte,
  input  logic             gte,
  output logic             redirect_valid,
  output logic [WIDTH-1:0] redirect_pc,
  output logic             link_we,
  output logic             link_dest31,
  output logic [WIDTH-1:0] link_data,
  output logic             slot_fault,
  output logic             busy
);

  localparam logic [3:0] c_OP_BEQ    = 4'd1;
  localparam logic [3:0] c_OP_BNE    = 4'd2;
  localparam logic [3:0] c_OP_BLTZ   = 4'd3;
  localparam logic [3:0] c_OP_BGEZ   = 4'd4;
  localparam logic [3:0] c_OP_BLEZ   = 4'd5;
  localparam logic [3:0] c_OP_BGTZ   = 4'd6;
  localparam logic [3:0] c_OP_BLTZAL = 4'd7;
  localparam logic [3:0] c_OP_BGEZAL = 4'd8;
  localparam logic [3:0] c_OP_J      = 4'd9;
  localparam logic [3:0] c_OP_JAL    = 4'd10;
  localparam logic [3:0] c_OP_JR     = 4'd11;
  localparam logic [3:0] c_OP_JALR   = 4'd12;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SLOT = 1'b1
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_target;

  logic             w_accept;
  logic             w_taken;
  logic             w_is_branch;
  logic             w_links;
  logic [WIDTH-1:0] w_pc4;
  logic [WIDTH-1:0] w_target;

  assign w_accept    = in_valid & ~stall;
  assign w_is_branch = (in_op >= c_OP_BEQ) && (in_op <= c_OP_JALR);
  assign w_links     = (in_op == c_OP_BLTZAL) || (in_op == c_OP_BGEZAL) ||
                       (in_op == c_OP_JAL)    || (in_op == c_OP_JALR);
  assign w_pc4       = in_pc + WIDTH'(4);

  always_comb begin
    w_taken  = 1'b0;
    w_target = w_pc4 + {{(WIDTH-18){in_imm[15]}}, in_imm, 2'b00};
    case (in_op)
      c_OP_BEQ:                 w_taken = eq;
      c_OP_BNE:                 w_taken = neq;
      c_OP_BLTZ, c_OP_BLTZAL:   w_taken = lt;
      c_OP_BGEZ, c_OP_BGEZAL:   w_taken = gte;
      c_OP_BLEZ:                w_taken = lte;
      c_OP_BGTZ:                w_taken = gt;
      c_OP_J, c_OP_JAL: begin
        w_taken  = 1'b1;
        w_target = {w_pc4[WIDTH-1 -: 4], in_index, 2'b00};
      end
      c_OP_JR, c_OP_JALR: begin
        w_taken  = 1'b1;
        w_target = in_rs;
      end
      default:                  w_taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= IDLE;
      r_target       <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      link_we        <= 1'b0;
      link_dest31    <= 1'b0;
      link_data      <= '0;
      slot_fault     <= 1'b0;
      busy           <= 1'b0;
    end else begin
      redirect_valid <= 1'b0;
      link_we        <= 1'b0;
      slot_fault     <= 1'b0;
      if (w_accept) begin
        // Linking ops write the return address regardless of outcome or state.
        if (w_links) begin
          link_we     <= 1'b1;
          link_data   <= in_pc + WIDTH'(8);
          link_dest31 <= (in_op != c_OP_JALR);
        end
        case (r_state)
          IDLE: begin
            if (w_taken) begin
              r_target <= w_target;
              r_state  <= SLOT;
              busy     <= 1'b1;
            end
          end
          SLOT: begin
            redirect_valid <= 1'b1;
            redirect_pc    <= r_target;
            slot_fault     <= w_is_branch;
            r_state        <= IDLE;
            busy           <= 1'b0;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_branch_resolve.sv
// ============================================================================
//  tb_branch_resolve : directed self-checking bench for branch_resolve
//  Rev 1.0
// ============================================================================
`default_nettype none

module tb_branch_resolve;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        in_valid;
  logic [3:0]  in_op;
  logic [31:0] in_pc;
  logic [15:0] in_imm;
  logic [25:0] in_index;
  logic [31:0] in_rs;
  logic        lt, eq, neq, gt, lte, gte;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        link_we;
  logic        link_dest31;
  logic [31:0] link_data;
  logic        slot_fault;
  logic        busy;

  int total  = 0;
  int passes = 0;

  always #5 clk = ~clk;

  branch_resolve #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .stall(stall), .in_valid(in_valid),
    .in_op(in_op), .in_pc(in_pc), .in_imm(in_imm), .in_index(in_index),
    .in_rs(in_rs), .lt(lt), .eq(eq), .neq(neq), .gt(gt), .lte(lte), .gte(gte),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .link_we(link_we), .link_dest31(link_dest31), .link_data(link_data),
    .slot_fault(slot_fault), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  // Advance one clock and sample 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] pc,
                       input logic [15:0] imm, input logic [25:0] idx,
                       input logic [31:0] rs);
    in_valid = 1'b1;
    in_op    = op;
    in_pc    = pc;
    in_imm   = imm;
    in_index = idx;
    in_rs    = rs;
  endtask

  task automatic flags(input logic f_lt, input logic f_eq, input logic f_neq,
                       input logic f_gt, input logic f_lte, input logic f_gte);
    lt = f_lt; eq = f_eq; neq = f_neq; gt = f_gt; lte = f_lte; gte = f_gte;
  endtask

  task automatic idle_in();
    in_valid = 1'b0;
    in_op    = 4'd0;
    flags(0, 0, 0, 0, 0, 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".rv"},   {31'd0, redirect_valid}, 32'd0);
    chk({tag, ".rpc"},  redirect_pc,             32'd0);
    chk({tag, ".lwe"},  {31'd0, link_we},        32'd0);
    chk({tag, ".l31"},  {31'd0, link_dest31},    32'd0);
    chk({tag, ".ld"},   link_data,               32'd0);
    chk({tag, ".sf"},   {31'd0, slot_fault},     32'd0);
    chk({tag, ".busy"}, {31'd0, busy},           32'd0);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0;
    in_pc = '0; in_imm = '0; in_index = '0; in_rs = '0;
    idle_in();
    tick(); tick();
    chk_all_zero("reset");
    rst = 1'b0;

    // BEQ not taken: nothing happens
    issue(4'd1, 32'h0040_0000, 16'h0004, 26'd0, 32'd0); flags(0, 0, 1, 0, 0, 0);
    tick();
    chk("beq_nt.busy", {31'd0, busy}, 32'd0);
    chk("beq_nt.rv", {31'd0, redirect_valid}, 32'd0);
    chk("beq_nt.lwe", {31'd0, link_we}, 32'd0);

    // BEQ taken, delay slot op 0
    flags(0, 1, 0, 0, 1, 1);
    tick();
    chk("beq.busy", {31'd0, busy}, 32'd1);
    chk("beq.rv0", {31'd0, redirect_valid}, 32'd0);
    issue(4'd0, 32'h0040_0004, 16'h0, 26'd0, 32'd0); flags(0, 0, 0, 0, 0, 0);
    tick();
    chk("beq.rv", {31'd0, redirect_valid}, 32'd1);
    chk("beq.rpc", redirect_pc, 32'h0040_0014);
    chk("beq.busy_fall", {31'd0, busy}, 32'd0);
    chk("beq.sf", {31'd0, slot_fault}, 32'd0);
    idle_in();
    tick();
    chk("beq.rv_pulse", {31'd0, redirect_valid}, 32'd0);
    chk("beq.rpc_hold", redirect_pc, 32'h0040_0014);

    // BNE backwards by one word lands on itself
    issue(4'd2, 32'h0, 16'hFFFF, 26'd0, 32'd0); flags(0, 0, 1, 0, 0, 0);
    tick();
    issue(4'd0, 32'h4, 16'h0, 26'd0, 32'd0); flags(0, 0, 0, 0, 0, 0);
    tick();
    chk("bne_m1.rv", {31'd0, redirect_valid}, 32'd1);
    chk("bne_m1.rpc", redirect_pc, 32'h0000_0000);

    // BNE most-negative offset wraps
    issue(4'd2, 32'h0, 16'h8000, 26'd0, 32'd0); flags(0, 0, 1, 0, 0, 0);
    tick();
    issue(4'd0, 32'h4, 16'h0, 26'd0, 32'd0); flags(0, 0, 0, 0, 0, 0);
    tick();
    chk("bne_wrap.rv", {31'd0, redirect_valid}, 32'd1);
    chk("bne_wrap.rpc", redirect_pc, 32'hFFFE_0004);

    // JAL: link then region jump
    issue(4'd10, 32'h1FFF_FFF8, 16'h0, 26'h000_0010, 32'd0); flags(0, 0, 0, 0, 0, 0);
    tick();
    chk("jal.lwe", {31'd0, link_we}, 32'd1);
    chk("jal.l31", {31'd0, link_dest31}, 32'd1);
    chk("jal.ld", link_data, 32'h2000_0000);
    chk("jal.busy", {31'd0, busy}, 32'd1);
    issue(4'd0, 32'h1FFF_FFFC, 16'h0, 26'd0, 32'd0);
    tick();
    chk("jal.lwe_pulse", {31'd0, link_we}, 32'd0);
    chk("jal.rv", {31'd0, redirect_valid}, 32'd1);
    chk("jal.rpc", redirect_pc, 32'h1000_0040);
    chk("jal.ld_hold", link_data, 32'h2000_0000);

    // BLTZAL not taken still links
    issue(4'd7, 32'h0000_0100, 16'h0010, 26'd0, 32'd0); flags(0, 0, 1, 1, 0, 1);
    tick();
    chk("bltzal.lwe", {31'd0, link_we}, 32'd1);
    chk("bltzal.l31", {31'd0, link_dest31}, 32'd1);
    chk("bltzal.ld", link_data, 32'h0000_0108);
    chk("bltzal.busy", {31'd0, busy}, 32'd0);

    // JALR links to rd
    issue(4'd12, 32'h0000_0200, 16'h0, 26'd0, 32'h0000_0300); flags(0, 0, 0, 0, 0, 0);
    tick();
    chk("jalr.lwe", {31'd0, link_we}, 32'd1);
    chk("jalr.l31", {31'd0, link_dest31}, 32'd0);
    chk("jalr.ld", link_data, 32'h0000_0208);
    issue(4'd0, 32'h0000_0204, 16'h0, 26'd0, 32'd0);
    tick();
    chk("jalr.rv", {31'd0, redirect_valid}, 32'd1);
    chk("jalr.rpc", redirect_pc, 32'h0000_0300);

    // JR with stalled delay slot
    issue(4'd11, 32'h0000_1000, 16'h0, 26'd0, 32'h8000_1234);
    tick();
    chk("jr.busy", {31'd0, busy}, 32'd1);
    issue(4'd0, 32'h0000_1004, 16'h0, 26'd0, 32'd0);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("jr_stall.busy", {31'd0, busy}, 32'd1);
      chk("jr_stall.rv", {31'd0, redirect_valid}, 32'd0);
    end
    stall = 1'b0;
    tick();
    chk("jr.rv", {31'd0, redirect_valid}, 32'd1);
    chk("jr.rpc", redirect_pc, 32'h8000_1234);
    chk("jr.busy_fall", {31'd0, busy}, 32'd0);

    // JR with J in the delay slot: fault, first target wins
    issue(4'd11, 32'h0000_2000, 16'h0, 26'd0, 32'h0000_0100);
    tick();
    issue(4'd9, 32'h0000_2004, 16'h0, 26'h000_0040, 32'd0);
    tick();
    chk("slotj.sf", {31'd0, slot_fault}, 32'd1);
    chk("slotj.rv", {31'd0, redirect_valid}, 32'd1);
    chk("slotj.rpc", redirect_pc, 32'h0000_0100);
    chk("slotj.busy", {31'd0, busy}, 32'd0);
    idle_in();
    tick();
    chk("slotj.rv2", {31'd0, redirect_valid}, 32'd0);
    chk("slotj.sf2", {31'd0, slot_fault}, 32'd0);
    chk("slotj.busy2", {31'd0, busy}, 32'd0);

    // Reset while in SLOT discards the redirect
    issue(4'd11, 32'h0000_3000, 16'h0, 26'd0, 32'h0000_0500);
    tick();
    chk("rstslot.busy", {31'd0, busy}, 32'd1);
    idle_in();
    rst = 1'b1;
    tick();
    chk_all_zero("rstslot");
    rst = 1'b0;
    issue(4'd0, 32'h0000_3004, 16'h0, 26'd0, 32'd0);
    tick();
    chk("rstslot.rv_after", {31'd0, redirect_valid}, 32'd0);
    chk("rstslot.busy_after", {31'd0, busy}, 32'd0);
    idle_in();
    tick();
    chk("rstslot.rv_after2", {31'd0, redirect_valid}, 32'd0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

`default_nettype wire
